// File: rtl/edge_event_reader_if.sv
// Bundle of event strobes, pending/overflow status and the valid/ready drain port.
// Pure wiring, no latency.
// Backpressure is carried by evt_ready_i; the slave side holds evt_idx_o while stalled.
interface edge_event_reader_if #(
    parameter int WIDTH = 32
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] edge_i;
    logic             evt_valid_o;
    logic             evt_ready_i;
    logic [IDX_W-1:0] evt_idx_o;
    logic [WIDTH-1:0] pending_o;
    logic             ovf_o;
    logic             ovf_clr_i;

    // Reader side (the design)
    modport slave (
        input  edge_i,
        input  evt_ready_i,
        input  ovf_clr_i,
        output evt_valid_o,
        output evt_idx_o,
        output pending_o,
        output ovf_o
    );

    // Capture stage plus consumer side
    modport master (
        output edge_i,
        output evt_ready_i,
        output ovf_clr_i,
        input  evt_valid_o,
        input  evt_idx_o,
        input  pending_o,
        input  ovf_o
    );
endinterface

// File: rtl/edge_event_reader.sv
// Collects per-bit edge strobes into a pending vector and drains them round-robin as indices.
// Edge in cycle N -> pending at N+1 -> earliest evt_valid_o at N+2; 1 event/cycle when ready stays high.
// While stalled the held index is stable, pending keeps accumulating and repeats set the sticky overflow.
module edge_event_reader #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    edge_event_reader_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_VALID = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_pending;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic             r_ovf;

    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_ptr_next;
    int               w_sel_j;
    logic             w_any;
    logic             w_xfer;
    logic             w_load;
    logic [WIDTH-1:0] w_load_mask;
    logic [WIDTH-1:0] w_pending_next;
    logic             w_ovf_set;

    // Round-robin pick: lowest offset from r_ptr (with wrap) that is pending wins
    always_comb begin
        w_win   = '0;
        w_sel_j = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_sel_j = int'(r_ptr) + i;
            if (w_sel_j >= WIDTH) w_sel_j = w_sel_j - WIDTH;
            if (r_pending[IDX_W'(w_sel_j)]) w_win = IDX_W'(w_sel_j);
        end
    end

    // The holding register is free when empty or when its current index transfers this cycle
    always_comb begin
        w_any          = |r_pending;
        w_xfer         = (r_state == ST_VALID) && bus.evt_ready_i;
        w_load         = ((r_state == ST_IDLE) || w_xfer) && w_any;
        w_load_mask    = w_load ? (WIDTH'(1) << w_win) : '0;
        // A fresh edge on the bit being loaded re-pends, so OR-in after the clear
        w_pending_next = (r_pending & ~w_load_mask) | bus.edge_i;
        w_ovf_set      = |(bus.edge_i & r_pending & ~w_load_mask);
        w_ptr_next     = (w_win == IDX_W'(WIDTH - 1)) ? '0 : (w_win + IDX_W'(1));
    end

    // Pending vector and sticky overflow; a new overflow beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (bus.ovf_clr_i)
                r_ovf <= 1'b0;
        end
    end

    // Output holding FSM: load winner and advance pointer, or fall back to idle after the last transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_load) begin
                r_state <= ST_VALID;
                r_idx   <= w_win;
                r_ptr   <= w_ptr_next;
            end else if (w_xfer) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign bus.evt_valid_o = (r_state == ST_VALID);
    assign bus.evt_idx_o   = r_idx;
    assign bus.pending_o   = r_pending;
    assign bus.ovf_o       = r_ovf;
endmodule

// File: tb/tb_edge_event_reader.sv
// Directed bench for edge_event_reader: reset, single event, burst, fairness, stall/overflow, async reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-derived constants for each step.
module tb_edge_event_reader;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    edge_event_reader_if #(.WIDTH(WIDTH)) bus ();

    edge_event_reader #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input logic v, input logic [4:0] idx);
        chk({tag, "_vld"}, 64'(bus.evt_valid_o), 64'(v));
        if (v) chk({tag, "_idx"}, 64'(bus.evt_idx_o), 64'(idx));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.edge_i      = '1;
        bus.evt_ready_i = 1'b1;
        bus.ovf_clr_i   = 1'b0;

        // Reset held with all edges asserted
        tick();
        tick();
        chk("rst_vld", 64'(bus.evt_valid_o), 64'd0);
        chk("rst_idx", 64'(bus.evt_idx_o), 64'd0);
        chk("rst_pend", 64'(bus.pending_o), 64'd0);
        chk("rst_ovf", 64'(bus.ovf_o), 64'd0);
        bus.edge_i = '0;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_vld", 64'(bus.evt_valid_o), 64'd0);
        end

        // Single event on bit 5
        bus.edge_i = 32'h0000_0020;
        tick();
        bus.edge_i = '0;
        chk("single_c1_pend", 64'(bus.pending_o), 64'h20);
        chk("single_c1_vld", 64'(bus.evt_valid_o), 64'd0);
        tick();
        chk_evt("single_c2", 1'b1, 5'd5);
        chk("single_c2_pend", 64'(bus.pending_o), 64'h0);
        tick();
        chk("single_c3_vld", 64'(bus.evt_valid_o), 64'd0);

        // Burst, back-to-back drain from pointer 0
        pulse_reset();
        bus.edge_i = 32'h8000_0011;
        tick();
        bus.edge_i = '0;
        chk("burst_c1_pend", 64'(bus.pending_o), 64'h8000_0011);
        tick();
        chk_evt("burst_c2", 1'b1, 5'd0);
        chk("burst_c2_pend", 64'(bus.pending_o), 64'h8000_0010);
        tick();
        chk_evt("burst_c3", 1'b1, 5'd4);
        tick();
        chk_evt("burst_c4", 1'b1, 5'd31);
        tick();
        chk("burst_c5_vld", 64'(bus.evt_valid_o), 64'd0);

        // Fairness: bit 0 re-pulsed while bit 4 still waits
        pulse_reset();
        bus.edge_i = 32'h0000_0011;
        tick();
        bus.edge_i = '0;
        tick();
        chk_evt("rr_c2", 1'b1, 5'd0);
        bus.edge_i = 32'h0000_0001;
        tick();
        bus.edge_i = '0;
        chk_evt("rr_c3", 1'b1, 5'd4);
        chk("rr_c3_pend", 64'(bus.pending_o), 64'h1);
        tick();
        chk_evt("rr_c4", 1'b1, 5'd0);
        tick();
        chk("rr_c5_vld", 64'(bus.evt_valid_o), 64'd0);

        // Stall with repeated edges on bit 3
        pulse_reset();
        bus.evt_ready_i = 1'b0;
        bus.edge_i = 32'h0000_0008;
        tick();
        bus.edge_i = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_evt("stall_hold", 1'b1, 5'd3);
        end
        bus.edge_i = 32'h0000_0008;
        tick();
        bus.edge_i = '0;
        chk("stall_repend", 64'(bus.pending_o), 64'h8);
        chk("stall_no_ovf", 64'(bus.ovf_o), 64'd0);
        bus.edge_i = 32'h0000_0008;
        tick();
        bus.edge_i = '0;
        chk("stall_ovf", 64'(bus.ovf_o), 64'd1);
        chk_evt("stall_still", 1'b1, 5'd3);
        bus.evt_ready_i = 1'b1;
        tick();
        chk_evt("drain_2nd", 1'b1, 5'd3);
        chk("drain_pend", 64'(bus.pending_o), 64'h0);
        tick();
        chk("drain_done_vld", 64'(bus.evt_valid_o), 64'd0);
        chk("ovf_sticky", 64'(bus.ovf_o), 64'd1);
        bus.ovf_clr_i = 1'b1;
        tick();
        bus.ovf_clr_i = 1'b0;
        chk("ovf_clr", 64'(bus.ovf_o), 64'd0);

        // Clear coincident with a new overflow: set wins
        bus.evt_ready_i = 1'b0;
        bus.edge_i = 32'h0000_0008;
        tick();
        bus.edge_i = '0;
        tick();
        chk_evt("ovf2_held", 1'b1, 5'd3);
        bus.edge_i = 32'h0000_0008;
        tick();
        bus.edge_i = 32'h0000_0008;
        bus.ovf_clr_i = 1'b1;
        tick();
        bus.edge_i = '0;
        bus.ovf_clr_i = 1'b0;
        chk("ovf_set_wins", 64'(bus.ovf_o), 64'd1);

        // Async reset between edges while valid and pending
        chk("pre_arst_vld", 64'(bus.evt_valid_o), 64'd1);
        chk("pre_arst_pend", 64'(bus.pending_o), 64'h8);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_vld", 64'(bus.evt_valid_o), 64'd0);
        chk("arst_pend", 64'(bus.pending_o), 64'h0);
        chk("arst_ovf", 64'(bus.ovf_o), 64'd0);
        tick();
        reset = 1'b1;
        bus.evt_ready_i = 1'b1;
        bus.edge_i = 32'h0000_0080;
        tick();
        bus.edge_i = '0;
        chk("post_c1_vld", 64'(bus.evt_valid_o), 64'd0);
        tick();
        chk_evt("post_c2", 1'b1, 5'd7);

        // Pointer now 8: bits 2 and 9 pend, 9 is found first
        bus.edge_i = 32'h0000_0204;
        tick();
        bus.edge_i = '0;
        tick();
        chk_evt("wrap_a", 1'b1, 5'd9);
        tick();
        chk_evt("wrap_b", 1'b1, 5'd2);
        tick();
        chk("wrap_end_vld", 64'(bus.evt_valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/edge_event_reader.md
Name: edge_event_reader

Overview:
- Drain side of the edge-capture path.
- Accepts per-bit single-cycle edge strobes from a capture stage and holds them in a pending vector.
- Hands pending events to a consumer one at a time over a valid/ready interface, as a bit index.
- Round-robin selection prevents starvation. Serving an event clears its pending bit (read-to-clear semantics). A sticky overflow flag reports events that were merged while a bit was already pending.

Parameters:
- WIDTH, 32, number of edge sources (2..64).
- IDX_W, $clog2(WIDTH), width of evt_idx_o (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; asserting (low) clears all state immediately.
- edge_i  input  WIDTH  edge strobes; bit b high for one cycle = one event on source b; multiple bits may be high together.
- evt_valid_o  output  1  event presented on evt_idx_o.
- evt_ready_i  input  1  consumer accepts; transfer when evt_valid_o & evt_ready_i.
- evt_idx_o  output  IDX_W  index of presented source.
- pending_o  output  WIDTH  current pending vector (registered).
- ovf_o  output  1  sticky overflow flag.
- ovf_clr_i  input  1  clears ovf_o.

Behaviour:
- Reset values: pending 0, evt_valid_o 0, evt_idx_o 0, ovf_o 0, round-robin pointer ptr 0. Reset low mid-transfer drops evt_valid_o asynchronously and discards all pending events.
- All outputs are registered.
- Output holding register FSM, two states:
  - IDLE: evt_valid_o=0. If pending != 0: load the winner into evt_idx_o, clear its pending bit, go to VALID.
  - VALID: evt_valid_o=1 and evt_idx_o held stable until transfer; it never changes while stalled.
  - On transfer, if pending (after this cycle's clear) != 0: load the next winner in the same cycle and stay in VALID, giving throughput of 1 event/cycle.
  - On transfer with pending == 0: go to IDLE.
- Winner selection: first set bit of pending_q searching upward from ptr, wrapping from WIDTH-1 to 0. On each load of index k, ptr <= (k+1) mod WIDTH.
- Selection uses pending_q only. edge_i arriving in cycle N sets pending at N+1. The earliest evt_valid_o for an edge seen at cycle N from IDLE is cycle N+2.
- Pending update: pending_next = (pending_q & ~load_mask) | edge_i.
  - If edge_i[b] and a load of b occur together, b stays pending. This is a new event and is never lost.
- Overflow condition: edge_i[b]=1 while pending_q[b]=1 and b is not being loaded that cycle.
  - On overflow: events merge and ovf_o <= 1 next cycle.
  - An edge on the bit currently held in evt_idx_o but not pending is not overflow; it re-pends.
- ovf_clr_i clears ovf_o next cycle. If a new overflow occurs in the same cycle as ovf_clr_i, set wins and ovf_o stays 1.
- evt_ready_i while evt_valid_o=0 is ignored.
- Stall: while in VALID with evt_ready_i=0, pending continues to accumulate and no loads occur.

Test Plan:
- Reset: hold reset low with edge_i=all-ones -> all outputs 0. Release, no edges -> evt_valid_o stays 0 for 20 cycles.
- Single event: edge_i=0x0000_0020 at cycle 0, ready=1 -> pending_o=0x20 at cycle 1; evt_valid_o=1, evt_idx_o=5 at cycle 2 for exactly one cycle; pending_o=0 at cycle 2.
- Burst + back-to-back: edge_i=0x8000_0011 for one cycle, ready=1 -> evt_idx_o 0,4,31 on consecutive cycles 2,3,4; valid low from cycle 5.
- Round-robin fairness: after serving idx 0 (ptr=1), pulse bit 0 again while bit 4 pending -> order 0,4,0, not 0,0,4.
- Backpressure/overflow: ready=0, edge on bit 3 -> idx 3 held stable 10 cycles.
  - Edge on bit 3 again -> pending_o[3]=1, ovf_o=0.
  - A third edge on bit 3 -> ovf_o=1 next cycle.
  - Release ready -> 3 delivered twice total.
  - Pulse ovf_clr_i -> ovf_o=0; clr coincident with a new overflow -> ovf_o stays 1.
- Async reset mid-stream: assert reset between clock edges while evt_valid_o=1 and pending_o nonzero -> evt_valid_o, pending_o, ovf_o drop to 0 before the next edge. After release, the first edge on bit 7 yields idx 7 (ptr restarted at 0).
